// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the memory controller: FSM states, request size codes,
// load/store tags and byte helpers.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    MC_IDLE     = 3'd0,
    MC_IF_READ  = 3'd1,
    MC_LS_READ  = 3'd2,
    MC_LS_WRITE = 3'd3,
    MC_DONE     = 3'd4
  } mc_state_e;

  localparam logic [2:0] SIZE_B = 3'b001;
  localparam logic [2:0] SIZE_H = 3'b010;
  localparam logic [2:0] SIZE_W = 3'b100;

  localparam logic LOAD  = 1'b0;
  localparam logic STORE = 1'b1;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Unknown size codes fall back to a full word.
  function automatic logic [2:0] size_bytes(input logic [2:0] op);
    case (op)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] k);
    return w[8*k +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_assembler.sv
// Little-endian byte accumulator: merges one byte per cycle into a 32-bit word.
// o_word_next exposes the merged word so a finishing edge can register it directly.
module mem_byte_assembler
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_we,
  input  logic [1:0]  i_idx,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word_next
);

  logic [31:0] r_word;

  always_comb begin
    o_word_next = i_clr ? 32'd0 : r_word;
    if (i_we) o_word_next[8*i_idx +: 8] = i_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_word <= 32'd0;
    else if (i_en) r_word <= o_word_next;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates LSB and instruction-fetch requests onto
// a byte-wide synchronous RAM/IO bus. Optional IO back-pressure: MEM_CTRL_IO_STALL_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_BASE_HI = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              jump_flag,
  input  logic              if_enable,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_success,
  output logic [31:0]       if_data,
  input  logic              lsb_enable,
  input  logic [2:0]        lsb_op_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  input  logic              lsb_wr_tag,
  output logic              lsb_success,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  input  logic              io_buffer_full
);

  mc_state_e         r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [2:0]        r_n;
  logic [2:0]        r_cnt;
  logic              r_is_io;
  logic              r_if_success, r_lsb_success, r_ram_wr;
  logic [31:0]       r_if_data, r_lsb_rdata;
  logic [7:0]        r_ram_dout;
  logic [ADDR_W-1:0] r_ram_a;

  logic              w_lsb_io, w_io_block, w_wr_stall;
  logic              w_accept_ls, w_accept_if, w_rd_state, w_abort;
  logic [2:0]        w_cnt_inc;
  logic [1:0]        w_asm_idx;
  logic [31:0]       w_word_next;

  assign w_lsb_io    = (lsb_addr[17:16] == IO_BASE_HI);
  assign w_accept_ls = (r_state == MC_IDLE) && lsb_enable && !w_io_block;
  assign w_accept_if = (r_state == MC_IDLE) && !lsb_enable && if_enable && !jump_flag;
  assign w_rd_state  = (r_state == MC_IF_READ) || (r_state == MC_LS_READ);
  assign w_abort     = (r_state == MC_IF_READ) && jump_flag;
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_asm_idx   = r_cnt[1:0] - 2'd1;

`ifdef MEM_CTRL_IO_STALL_EN
  assign w_io_block = (lsb_wr_tag == STORE) && w_lsb_io && io_buffer_full;
  assign w_wr_stall = (r_state == MC_LS_WRITE) && r_is_io && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = io_buffer_full ^ r_is_io;
  assign w_io_block  = FALSE;
  assign w_wr_stall  = FALSE;
`endif

  // Byte k of a read lands on ram_din while r_cnt == k+1.
  mem_byte_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .i_en        (rdy),
    .i_clr       (w_accept_ls || w_accept_if),
    .i_we        (w_rd_state && !w_abort && (r_cnt != 3'd0)),
    .i_idx       (w_asm_idx),
    .i_byte      (ram_din),
    .o_word_next (w_word_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= MC_IDLE;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_n           <= '0;
      r_cnt         <= '0;
      r_is_io       <= FALSE;
      r_if_success  <= FALSE;
      r_lsb_success <= FALSE;
      r_ram_wr      <= FALSE;
      r_if_data     <= '0;
      r_lsb_rdata   <= '0;
      r_ram_dout    <= '0;
      r_ram_a       <= '0;
    end else if (rdy) begin
      case (r_state)
        MC_IDLE: begin
          r_cnt <= 3'd0;
          if (w_accept_ls) begin
            r_addr  <= lsb_addr;
            r_wdata <= lsb_wdata;
            r_n     <= size_bytes(lsb_op_size);
            r_is_io <= w_lsb_io;
            r_ram_a <= lsb_addr;
            if (lsb_wr_tag == STORE) begin
              r_state    <= MC_LS_WRITE;
              r_ram_wr   <= TRUE;
              r_ram_dout <= lsb_wdata[7:0];
            end else begin
              r_state <= MC_LS_READ;
            end
          end else if (w_accept_if) begin
            r_addr  <= if_addr;
            r_n     <= SIZE_W;
            r_is_io <= FALSE;
            r_ram_a <= if_addr;
            r_state <= MC_IF_READ;
          end
        end
        MC_IF_READ, MC_LS_READ: begin
          if (w_abort) begin
            r_state <= MC_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc < r_n) r_ram_a <= r_addr + ADDR_W'(w_cnt_inc);
            if (r_cnt == r_n) begin
              r_state <= MC_DONE;
              if (r_state == MC_IF_READ) begin
                r_if_success <= TRUE;
                r_if_data    <= w_word_next;
              end else begin
                r_lsb_success <= TRUE;
                r_lsb_rdata   <= w_word_next;
              end
            end
          end
        end
        MC_LS_WRITE: begin
          if (!w_wr_stall) begin
            if (w_cnt_inc < r_n) begin
              r_cnt      <= w_cnt_inc;
              r_ram_a    <= r_addr + ADDR_W'(w_cnt_inc);
              r_ram_dout <= get_byte(r_wdata, w_cnt_inc[1:0]);
            end else begin
              r_ram_wr      <= FALSE;
              r_lsb_success <= TRUE;
              r_state       <= MC_DONE;
            end
          end
        end
        MC_DONE: begin
          r_if_success  <= FALSE;
          r_lsb_success <= FALSE;
          r_state       <= MC_IDLE;
        end
        default: r_state <= MC_IDLE;
      endcase
    end
  end

  assign if_success  = r_if_success;
  assign if_data     = r_if_data;
  assign lsb_success = r_lsb_success;
  assign lsb_rdata   = r_lsb_rdata;
  assign ram_dout    = r_ram_dout;
  assign ram_a       = r_ram_a;
  // A frozen or back-pressured write cycle must not be seen by the RAM.
  assign ram_wr      = r_ram_wr && rdy && !w_wr_stall;

endmodule
